// File: rtl/wm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wm_pkg
// Description : Shared constants and encodings for the washer input path.
// Revision    : 1.0 - initial release
// ============================================================================
package wm_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 180000;

    localparam int SW_LOAD_LO = 0;
    localparam int SW_LOAD_HI = 1;
    localparam int SW_TEMP_LO = 2;
    localparam int SW_TEMP_HI = 3;
    localparam int SW_RINSE2  = 4;
    localparam int SW_XSPIN   = 5;
    localparam int SW_LID     = 6;

    typedef enum logic [1:0] {
        LOAD_SMALL   = 2'b00,
        LOAD_MEDIUM  = 2'b01,
        LOAD_LARGE   = 2'b10,
        LOAD_INVALID = 2'b11
    } load_e;

    typedef enum logic [1:0] {
        TEMP_COLD    = 2'b00,
        TEMP_WARM    = 2'b01,
        TEMP_HOT     = 2'b10,
        TEMP_INVALID = 2'b11
    } temp_e;

    // Bits [1:0] load, [3:2] temperature; both must avoid the reserved code.
    function automatic logic cfg_ok(input logic [3:0] sw);
        return (load_e'(sw[SW_LOAD_HI:SW_LOAD_LO]) != LOAD_INVALID) &&
               (temp_e'(sw[SW_TEMP_HI:SW_TEMP_LO]) != TEMP_INVALID);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wm_debounce.sv
`default_nettype none
// ============================================================================
// Module      : wm_debounce
// Description : One channel: 2-flop synchronizer, stability counter and clean
//               level with a parameterised reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module wm_debounce #(
    parameter int   DEBOUNCE_CYCLES = 180000,
    parameter int   CNT_WIDTH       = 18,
    parameter logic RST_LEVEL       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 sync1;
    logic                 sync2;
    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            clean <= RST_LEVEL;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any agreeing cycle restarts the stability window.
            if (sync2 == clean) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                clean <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wm_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : wm_input_conditioner
// Description : Debounces the washer switches and start button, produces a
//               one-cycle start pulse and a configuration-valid flag.
//               Optional macro WM_LID_LOCKOUT_EN drops presses while lid open.
// Revision    : 1.0 - initial release
// ============================================================================
module wm_input_conditioner
    import wm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_WIDTH       = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] sw_raw,
    input  logic       start_raw,
    output logic [6:0] sw_clean,
    output logic       start_pulse,
    output logic       cfg_valid
);

    logic start_clean;
    logic start_prev;
    logic start_rise;
    logic pulse_next;

    for (genvar i = 0; i < 7; i++) begin : g_sw
        wm_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_WIDTH       (CNT_WIDTH),
            .RST_LEVEL       (1'b0)
        ) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (sw_raw[i]),
            .clean (sw_clean[i])
        );
    end

    // Resetting high means a button held through reset must be released first.
    wm_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_WIDTH       (CNT_WIDTH),
        .RST_LEVEL       (1'b1)
    ) u_deb_start (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (start_raw),
        .clean (start_clean)
    );

    assign start_rise = start_clean & ~start_prev;

`ifdef WM_LID_LOCKOUT_EN
    assign pulse_next = start_rise & ~sw_clean[SW_LID];
`else
    assign pulse_next = start_rise;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_prev  <= 1'b1;
            start_pulse <= 1'b0;
        end else begin
            start_prev  <= start_clean;
            start_pulse <= pulse_next;
        end
    end

    assign cfg_valid = cfg_ok(sw_clean[3:0]);

endmodule
`default_nettype wire

// File: tb/tb_wm_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_wm_input_conditioner
// Description : Directed self-checking bench, DEBOUNCE_CYCLES = 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wm_input_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] sw_raw;
    logic       start_raw;
    logic [6:0] sw_clean;
    logic       start_pulse;
    logic       cfg_valid;

    int total = 0;
    int bad   = 0;
    int pulse_cnt = 0;
    int snap;

    wm_input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .CNT_WIDTH       (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_raw      (sw_raw),
        .start_raw   (start_raw),
        .sw_clean    (sw_clean),
        .start_pulse (start_pulse),
        .cfg_valid   (cfg_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start_pulse) pulse_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        sw_raw    = 7'h7F;
        start_raw = 1'b0;

        // Reset and release latency
        tick(2);
        check("rst_sw_clean", 32'(sw_clean), 32'h0);
        check("rst_pulse", 32'(start_pulse), 32'h0);
        check("rst_cfg_valid", 32'(cfg_valid), 32'h1);
        rst_n = 1'b1;
        tick(5);
        check("rel_sw_clean_5", 32'(sw_clean), 32'h0);
        tick(1);
        check("rel_sw_clean_6", 32'(sw_clean), 32'h7F);
        check("cfg_invalid_all1", 32'(cfg_valid), 32'h0);
        sw_raw = 7'h00;
        tick(10);
        check("settle_zero", 32'(sw_clean), 32'h0);
        check("no_pulse_after_rst", 32'(pulse_cnt), 32'h0);

        // Bounce on sw_raw[0]
        sw_raw[0] = 1'b1; tick(2);
        sw_raw[0] = 1'b0; tick(2);
        sw_raw[0] = 1'b1; tick(2);
        check("bounce_mid", 32'(sw_clean[0]), 32'h0);
        sw_raw[0] = 1'b0; tick(2);
        check("bounce_mid2", 32'(sw_clean[0]), 32'h0);
        sw_raw[0] = 1'b1;
        tick(5);
        check("bounce_final_5", 32'(sw_clean[0]), 32'h0);
        tick(1);
        check("bounce_final_6", 32'(sw_clean[0]), 32'h1);
        check("cfg_valid_0001", 32'(cfg_valid), 32'h1);

        // cfg_valid
        sw_raw[3:0] = 4'b0011;
        tick(6);
        check("sw_clean_0011", 32'(sw_clean), 32'h03);
        check("cfg_load_invalid", 32'(cfg_valid), 32'h0);
        sw_raw[3:0] = 4'b0001;
        tick(5);
        check("cfg_pending", 32'(cfg_valid), 32'h0);
        tick(1);
        check("cfg_recovered", 32'(cfg_valid), 32'h1);
        sw_raw[3:0] = 4'b1100;
        tick(6);
        check("cfg_temp_invalid", 32'(cfg_valid), 32'h0);
        sw_raw = 7'h00;
        tick(8);

        // Press timing, bounce rejection, second press
        snap = pulse_cnt;
        start_raw = 1'b1;
        tick(6);
        check("press_pulse_e6", 32'(start_pulse), 32'h0);
        tick(1);
        check("press_pulse_e7", 32'(start_pulse), 32'h1);
        tick(1);
        check("press_pulse_e8", 32'(start_pulse), 32'h0);
        tick(18);
        check("press_held_once", 32'(pulse_cnt - snap), 32'h1);
        start_raw = 1'b0;
        tick(10);
        start_raw = 1'b1; tick(3);
        start_raw = 1'b0; tick(10);
        check("start_bounce_ignored", 32'(pulse_cnt - snap), 32'h1);
        start_raw = 1'b1;
        tick(10);
        check("second_press", 32'(pulse_cnt - snap), 32'h2);
        start_raw = 1'b0;
        tick(10);

        // Reset mid-debounce discards the partial count
        sw_raw[4] = 1'b1;
        tick(4);
        rst_n = 1'b0;
        tick(1);
        check("midrst_clean", 32'(sw_clean), 32'h0);
        rst_n = 1'b1;
        tick(5);
        check("midrst_restart_5", 32'(sw_clean[4]), 32'h0);
        tick(1);
        check("midrst_restart_6", 32'(sw_clean[4]), 32'h1);
        sw_raw = 7'h00;
        tick(10);

        // Button held through reset
        snap = pulse_cnt;
        start_raw = 1'b1;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check("held_rst_no_pulse", 32'(pulse_cnt - snap), 32'h0);
        start_raw = 1'b0;
        tick(10);
        start_raw = 1'b1;
        tick(10);
        check("held_rst_repress", 32'(pulse_cnt - snap), 32'h1);
        start_raw = 1'b0;
        tick(10);

        // Lid open lockout
        sw_raw[6] = 1'b1;
        tick(8);
        check("lid_settled", 32'(sw_clean[6]), 32'h1);
        snap = pulse_cnt;
        start_raw = 1'b1;
        tick(12);
`ifdef WM_LID_LOCKOUT_EN
        check("lid_press", 32'(pulse_cnt - snap), 32'h0);
`else
        check("lid_press", 32'(pulse_cnt - snap), 32'h1);
`endif
        start_raw = 1'b0;
        sw_raw[6] = 1'b0;
        tick(10);
        start_raw = 1'b1;
        tick(10);
`ifdef WM_LID_LOCKOUT_EN
        check("lid_closed_press", 32'(pulse_cnt - snap), 32'h1);
`else
        check("lid_closed_press", 32'(pulse_cnt - snap), 32'h2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
